// File: rtl/xbar_sel_ctrl.sv
// xbar_sel_ctrl: round-robin select/grant producer for the crossbar mux array, with ESEL one cycle behind SEL.
// Optional hold timeout with a TOUT pulse is compiled in when XBAR_TIMEOUT_EN is defined.
module xbar_sel_ctrl #(
    parameter int N_IN     = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] esel,
    output logic [N_IN-1:0]  gnt,
    output logic             valid
`ifdef XBAR_TIMEOUT_EN
    ,
    output logic             tout
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel_n, win, idx;
    logic [N_IN-1:0] gnt_n;
    logic valid_n, found, rel, expire;
`ifdef XBAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic tout_n;
    assign expire = cnt == CNT_W'(MAX_HOLD - 1);
`else
    assign expire = 1'b0;
`endif
    // first requester at or above ptr, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            idx = SEL_W'((int'(ptr) + i) % N_IN);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    assign rel = done || !req[sel];
    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        valid_n = valid;
        ptr_n   = ptr;
`ifdef XBAR_TIMEOUT_EN
        cnt_n   = cnt;
        tout_n  = 1'b0;
`endif
        case (state)
            IDLE: if (found) begin
                state_n = BUSY;
                sel_n   = win;
                gnt_n   = N_IN'(1) << win;
                valid_n = 1'b1;
`ifdef XBAR_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            BUSY: if (rel || expire) begin
                state_n = RELEASE;
                gnt_n   = '0;
                valid_n = 1'b0;
                ptr_n   = (sel == SEL_W'(N_IN - 1)) ? '0 : sel + 1'b1;
`ifdef XBAR_TIMEOUT_EN
                tout_n  = !rel;
`endif
            end else begin
`ifdef XBAR_TIMEOUT_EN
                cnt_n   = cnt + 1'b1;
`endif
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            esel  <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            esel  <= sel;
            gnt   <= gnt_n;
            valid <= valid_n;
        end
    end
`ifdef XBAR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tout <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            tout <= tout_n;
        end
    end
`endif
endmodule

// File: tb/tb_xbar_sel_ctrl.sv
// tb_xbar_sel_ctrl: directed scenarios plus random traffic checked against a grant/owner reference model.
module tb_xbar_sel_ctrl;
    localparam int N = 4;
    localparam int MAX_HOLD = 16;
    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req;
    logic done;
    logic [1:0] sel, esel;
    logic [N-1:0] gnt;
    logic valid;
`ifdef XBAR_TIMEOUT_EN
    logic tout;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int owner, mptr, held, msel, mesel;
    bit turn, mtout;

    xbar_sel_ctrl #(.N_IN(N), .SEL_W(2), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel), .esel(esel), .gnt(gnt), .valid(valid)
`ifdef XBAR_TIMEOUT_EN
        , .tout(tout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; turn = 0; mptr = 0; held = 0; msel = 0; mesel = 0; mtout = 0;
    endtask

    task automatic model_edge();
        int nsel;
        bit normal, forced;
        nsel = msel;
        forced = 0;
        if (owner >= 0) begin
            normal = done || !req[owner];
`ifdef XBAR_TIMEOUT_EN
            forced = !normal && held == MAX_HOLD;
`endif
            if (normal || forced) begin
                mptr = (owner + 1) % N;
                owner = -1;
                turn = 1;
            end else held++;
        end else if (turn) turn = 0;
        else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (mptr + i) % N;
                if (req[c]) begin
                    owner = c; nsel = c; held = 1;
                    break;
                end
            end
        end
        mesel = msel;
        msel = nsel;
        mtout = forced;
    endtask

    task automatic compare();
        check("sel", int'(sel), msel);
        check("esel", int'(esel), mesel);
        check("gnt", int'(gnt), owner >= 0 ? (1 << owner) : 0);
        check("valid", int'(valid), owner >= 0 ? 1 : 0);
`ifdef XBAR_TIMEOUT_EN
        check("tout", int'(tout), int'(mtout));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        model_reset();
        #2 compare();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; done = 1'b0;
        model_reset();
        #12 compare();
        rst_n = 1'b1;
        // single request, ESEL trails one cycle
        req = 4'b0100;
        step(); step();
        check("esel_two", int'(esel), 2);
        done = 1'b1; step();
        done = 1'b0; req = 4'b0011; step(); step();
        check("wrap_sel0", int'(sel), 0);
        done = 1'b1; step();
        done = 1'b0; step(); step();
        check("skip_sel1", int'(sel), 1);
        // release by request drop
        req = 4'b0000; step();
        check("drop_valid", int'(valid), 0);
        req = 4'b1110; step(); step();
        check("after_drop_sel", int'(sel), 2);
        req = 4'b0000; step(); step();
        // round robin with everything requesting
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 16; i++) step();
        done = 1'b0; req = '0; step(); step(); step();
        // async reset mid-grant on input 3
        do_reset();
        req = 4'b1000; step();
        check("gnt3", int'(gnt), 8);
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare();
        #1 rst_n = 1'b1;
        req = 4'b1111; step();
        check("post_reset_sel", int'(sel), 0);
        req = '0; step(); step(); step();
`ifdef XBAR_TIMEOUT_EN
        // forced release after MAX_HOLD valid cycles
        req = 4'b0001;
        for (int i = 0; i < MAX_HOLD + 3; i++) step();
        req = '0; step(); step(); step();
        // normal release on the expiry edge wins
        req = 4'b0001; step();
        for (int i = 0; i < 40 && held < MAX_HOLD; i++) step();
        done = 1'b1; step();
        check("tout_prio", int'(tout), 0);
        done = 1'b0; req = '0; step(); step();
`endif
        // random traffic
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = req | 4'b0001;
            done = ($urandom_range(0, 7) == 0);
            step();
        end
        req = '0; done = 1'b0;
        step(); step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
